// File: rtl/clock_set_ctrl.sv
// HH:MM:SS timekeeping controller: 1 Hz prescaler, 24-hour counters,
// two-button time/alarm set FSM and a sticky alarm flag.
module clock_set_ctrl #(
    parameter int DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       alarm_en,
    input  logic       alarm_ack,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hr,
    output logic [5:0] alm_min,
    output logic [4:0] alm_hr,
    output logic [2:0] state,
    output logic       tick,
    output logic       alarm_ring
);

    // state    | meaning
    // S_RUN    | time advances on prescaler wrap
    // S_SET_HR | inc bumps hours
    // S_SET_MIN| inc bumps minutes, leaving clears seconds
    // S_SET_AHR| inc bumps alarm hours
    // S_SET_AMIN| inc bumps alarm minutes
    localparam logic [2:0] S_RUN      = 3'd0;
    localparam logic [2:0] S_SET_HR   = 3'd1;
    localparam logic [2:0] S_SET_MIN  = 3'd2;
    localparam logic [2:0] S_SET_AHR  = 3'd3;
    localparam logic [2:0] S_SET_AMIN = 3'd4;

    localparam int             PW       = $clog2(DIV);
    localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);

    logic [PW-1:0] presc;
    logic          mode_q;
    logic          inc_q;
    logic          mode_rise;
    logic          inc_rise;
    logic          run_tick;
    logic [2:0]    state_nx;
    logic [5:0]    sec_nx;
    logic [5:0]    min_nx;
    logic [4:0]    hr_nx;
    logic          sec_wrap;
    logic          min_wrap;
    logic          alarm_hit;

    assign mode_rise = mode_btn & ~mode_q;
    assign inc_rise  = inc_btn & ~inc_q;
    // A mode change in the wrap cycle wins; the tick is dropped with the prescaler.
    assign run_tick  = (state == S_RUN) && !mode_rise && (presc == PRE_LAST);

    always_comb begin
        state_nx = S_RUN;
        case (state)
            S_RUN:      state_nx = S_SET_HR;
            S_SET_HR:   state_nx = S_SET_MIN;
            S_SET_MIN:  state_nx = S_SET_AHR;
            S_SET_AHR:  state_nx = S_SET_AMIN;
            default:    state_nx = S_RUN;
        endcase
    end

    always_comb begin
        sec_wrap = (sec == 6'd59);
        min_wrap = (min == 6'd59);
        sec_nx   = sec_wrap ? 6'd0 : sec + 6'd1;
        min_nx   = min;
        hr_nx    = hr;
        if (sec_wrap) begin
            min_nx = min_wrap ? 6'd0 : min + 6'd1;
            if (min_wrap) begin
                hr_nx = (hr == 5'd23) ? 5'd0 : hr + 5'd1;
            end
        end
        alarm_hit = (sec_nx == 6'd0) && (min_nx == alm_min) && (hr_nx == alm_hr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= 1'b0;
            inc_q   <= 1'b0;
            presc   <= '0;
            state   <= S_RUN;
            tick    <= 1'b0;
            sec     <= 6'd0;
            min     <= 6'd0;
            hr      <= 5'd0;
            alm_min <= 6'd0;
            alm_hr  <= 5'd0;
        end else begin
            mode_q <= mode_btn;
            inc_q  <= inc_btn;
            tick   <= 1'b0;
            if (mode_rise) begin
                state <= state_nx;
                presc <= '0;
                if (state == S_SET_MIN) begin
                    sec <= 6'd0;
                end
            end else begin
                case (state)
                    S_RUN: begin
                        if (run_tick) begin
                            presc <= '0;
                            tick  <= 1'b1;
                            sec   <= sec_nx;
                            min   <= min_nx;
                            hr    <= hr_nx;
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    S_SET_HR: if (inc_rise) hr <= (hr == 5'd23) ? 5'd0 : hr + 5'd1;
                    S_SET_MIN: if (inc_rise) min <= (min == 6'd59) ? 6'd0 : min + 6'd1;
                    S_SET_AHR: if (inc_rise) alm_hr <= (alm_hr == 5'd23) ? 5'd0 : alm_hr + 5'd1;
                    S_SET_AMIN: if (inc_rise) alm_min <= (alm_min == 6'd59) ? 6'd0 : alm_min + 6'd1;
                    default: state <= S_RUN;
                endcase
            end
        end
    end

    // Clearing beats setting, so a held ack masks a match in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_ring <= 1'b0;
        end else if (alarm_ack || !alarm_en) begin
            alarm_ring <= 1'b0;
        end else if (run_tick && alarm_hit) begin
            alarm_ring <= 1'b1;
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with DIV=4: counting, wrap, set FSM,
// alarm set/clear and asynchronous reset.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode_btn;
    logic       inc_btn;
    logic       alarm_en;
    logic       alarm_ack;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;
    logic [5:0] alm_min;
    logic [4:0] alm_hr;
    logic [2:0] state;
    logic       tick;
    logic       alarm_ring;

    int checks   = 0;
    int failures = 0;

    clock_set_ctrl #(.DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .alarm_en(alarm_en), .alarm_ack(alarm_ack), .sec(sec), .min(min),
        .hr(hr), .alm_min(alm_min), .alm_hr(alm_hr), .state(state),
        .tick(tick), .alarm_ring(alarm_ring)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        mode_btn = 1'b1;
        step();
        mode_btn = 1'b0;
        step();
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            inc_btn = 1'b1;
            step();
            inc_btn = 1'b0;
            step();
        end
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        step();
        while (tick !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        if (tick !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL wait_tick: tick=%b after %0d cycles, required 1", tick, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        checks++;
        if ({sec, min, hr, alm_min, alm_hr, state, tick, alarm_ring} !== 36'd0) begin
            failures++;
            $display("FAIL reset: %0d:%0d:%0d alm %0d:%0d st=%0d tick=%b ring=%b, required all 0",
                     hr, min, sec, alm_hr, alm_min, state, tick, alarm_ring);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_run();
        for (int k = 1; k <= 240; k++) begin
            step();
            checks++;
            if (tick !== (k % 4 == 0) || sec !== 6'((k / 4) % 60) || min !== 6'(k / 240)) begin
                failures++;
                $display("FAIL run k=%0d: tick=%b sec=%0d min=%0d, required tick=%b sec=%0d min=%0d",
                         k, tick, sec, min, (k % 4 == 0), (k / 4) % 60, k / 240);
            end
        end
        repeat (8) step();
        checks++;
        if (sec !== 6'd2 || min !== 6'd1 || hr !== 5'd0) begin
            failures++;
            $display("FAIL run_extra: %0d:%0d:%0d, required 0:1:2", hr, min, sec);
        end
    endtask

    task automatic test_wrap();
        press_mode();
        press_inc(23);
        press_mode();
        press_inc(58);
        press_mode();
        checks++;
        if (state !== 3'd3 || hr !== 5'd23 || min !== 6'd59 || sec !== 6'd0) begin
            failures++;
            $display("FAIL preload: st=%0d %0d:%0d:%0d, required st=3 23:59:0", state, hr, min, sec);
        end
        press_mode();
        press_mode();
        checks++;
        if (state !== 3'd0 || tick !== 1'b0) begin
            failures++;
            $display("FAIL back_to_run: st=%0d tick=%b, required st=0 tick=0", state, tick);
        end
        for (int i = 0; i < 59; i++) wait_tick();
        checks++;
        if (hr !== 5'd23 || min !== 6'd59 || sec !== 6'd59) begin
            failures++;
            $display("FAIL pre_wrap: %0d:%0d:%0d, required 23:59:59", hr, min, sec);
        end
        wait_tick();
        checks++;
        if (hr !== 5'd0 || min !== 6'd0 || sec !== 6'd0 || tick !== 1'b1 || alarm_ring !== 1'b0) begin
            failures++;
            $display("FAIL full_wrap: %0d:%0d:%0d tick=%b ring=%b, required 0:0:0 tick=1 ring=0",
                     hr, min, sec, tick, alarm_ring);
        end
    endtask

    task automatic test_set_hr();
        press_mode();
        press_inc(25);
        checks++;
        if (hr !== 5'd1 || state !== 3'd1 || min !== 6'd0 || sec !== 6'd0) begin
            failures++;
            $display("FAIL set_hr_25: hr=%0d st=%0d min=%0d sec=%0d, required hr=1 st=1 min=0 sec=0",
                     hr, state, min, sec);
        end
        inc_btn = 1'b1;
        repeat (10) step();
        inc_btn = 1'b0;
        step();
        checks++;
        if (hr !== 5'd2 || tick !== 1'b0) begin
            failures++;
            $display("FAIL inc_hold: hr=%0d tick=%b, required hr=2 tick=0", hr, tick);
        end
        press_inc(22);
        checks++;
        if (hr !== 5'd0) begin
            failures++;
            $display("FAIL hr_wrap: hr=%0d, required 0", hr);
        end
    endtask

    task automatic test_same_cycle();
        mode_btn = 1'b1;
        inc_btn  = 1'b1;
        step();
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        step();
        checks++;
        if (state !== 3'd2 || hr !== 5'd0 || min !== 6'd0) begin
            failures++;
            $display("FAIL mode_inc_same: st=%0d hr=%0d min=%0d, required st=2 hr=0 min=0",
                     state, hr, min);
        end
    endtask

    task automatic test_alarm();
        press_mode();
        press_mode();
        press_inc(2);
        checks++;
        if (alm_hr !== 5'd0 || alm_min !== 6'd2 || state !== 3'd4) begin
            failures++;
            $display("FAIL alarm_set: alm=%0d:%0d st=%0d, required 0:2 st=4", alm_hr, alm_min, state);
        end
        alarm_en = 1'b1;
        press_mode();
        for (int i = 0; i < 119; i++) wait_tick();
        checks++;
        if (alarm_ring !== 1'b0 || min !== 6'd1 || sec !== 6'd59) begin
            failures++;
            $display("FAIL alarm_early: ring=%b time=%0d:%0d, required ring=0 time=1:59",
                     alarm_ring, min, sec);
        end
        wait_tick();
        checks++;
        if (alarm_ring !== 1'b1 || hr !== 5'd0 || min !== 6'd2 || sec !== 6'd0) begin
            failures++;
            $display("FAIL alarm_fire: ring=%b %0d:%0d:%0d, required ring=1 0:2:0",
                     alarm_ring, hr, min, sec);
        end
        repeat (3) step();
        press_mode();
        checks++;
        if (alarm_ring !== 1'b1 || state !== 3'd1 || tick !== 1'b0) begin
            failures++;
            $display("FAIL alarm_sticky: ring=%b st=%0d tick=%b, required ring=1 st=1 tick=0",
                     alarm_ring, state, tick);
        end
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        checks++;
        if (alarm_ring !== 1'b0) begin
            failures++;
            $display("FAIL alarm_ack: ring=%b, required 0", alarm_ring);
        end
    endtask

    task automatic test_ack_held();
        press_mode();
        press_mode();
        press_mode();
        press_inc(1);
        press_mode();
        checks++;
        if (state !== 3'd0 || alm_min !== 6'd3 || min !== 6'd2 || sec !== 6'd0) begin
            failures++;
            $display("FAIL ack_setup: st=%0d alm_min=%0d time=%0d:%0d, required st=0 alm_min=3 time=2:0",
                     state, alm_min, min, sec);
        end
        alarm_ack = 1'b1;
        for (int i = 0; i < 60; i++) wait_tick();
        checks++;
        if (alarm_ring !== 1'b0 || min !== 6'd3 || sec !== 6'd0) begin
            failures++;
            $display("FAIL ack_held: ring=%b time=%0d:%0d, required ring=0 time=3:0", alarm_ring, min, sec);
        end
        alarm_ack = 1'b0;
        for (int i = 0; i < 3; i++) wait_tick();
        checks++;
        if (alarm_ring !== 1'b0) begin
            failures++;
            $display("FAIL no_refire: ring=%b, required 0", alarm_ring);
        end
    endtask

    task automatic test_async_reset();
        press_mode();
        press_mode();
        press_mode();
        press_mode();
        press_inc(1);
        checks++;
        if (state !== 3'd4 || alm_min !== 6'd4) begin
            failures++;
            $display("FAIL reach_amin: st=%0d alm_min=%0d, required st=4 alm_min=4", state, alm_min);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sec, min, hr, alm_min, alm_hr, state, tick, alarm_ring} !== 36'd0) begin
            failures++;
            $display("FAIL async_reset: %0d:%0d:%0d alm %0d:%0d st=%0d tick=%b ring=%b, required all 0",
                     hr, min, sec, alm_hr, alm_min, state, tick, alarm_ring);
        end
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        mode_btn  = 1'b0;
        inc_btn   = 1'b0;
        alarm_en  = 1'b0;
        alarm_ack = 1'b0;
        test_reset();
        test_run();
        test_wrap();
        test_set_hr();
        test_same_cycle();
        test_alarm();
        test_ack_held();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
